vga_cmd_display: RTL and testbench



---
 rtl/vga_cmd_display.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_vga_cmd_display.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_cmd_display.sv
// ---------------------------------------------------------------------------
// vga_cmd_display
//
// VGA display engine driven from a single fast clock. A tick counter divides
// clk down to the pixel rate. The horizontal and vertical counters, the sync
// pulses and the RGB outputs are all registered together, so the sync levels
// and colours always match the hcount/vcount values being presented.
//
// A small read FSM pulls command bytes from an external FIFO. The FIFO has an
// active-low empty flag and an active-low read strobe. The bytes program two
// 3-channel colour palettes (A and B) and a 2-bit display mode:
//   mode 0: solid A
//   mode 1: A on the left half, B on the right half
//   mode 2: checkerboard
//   mode 3: blank
//
// Optional feature (macro VGA_CMD_FRAME_SYNC_EN):
//   When the macro is defined, commands write shadow registers. These are
//   copied into the active set on the wrap to (0,0), so a frame never tears.
//   When it is undefined, commands write the active registers directly.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   fifo_data    command byte from the FIFO
//   fifo_nef     FIFO not-empty flag
//   fifo_rd_n    FIFO read strobe, active low
//   hsync/vsync  sync outputs (polarity set by HSYNC_POL / VSYNC_POL)
//   red/green/blue  pixel colour, COLOR_W bits each
//   hcount/vcount   current pixel column / line
//   frame_start  one-clk pulse when the counters wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_cmd_display #(
    parameter int CLK_DIV        = 3,
    parameter int CNT_W          = 12,
    parameter int H_VISIBLE      = 800,
    parameter int H_FRONT        = 40,
    parameter int H_SYNC         = 128,
    parameter int H_BACK         = 88,
    parameter int V_VISIBLE      = 600,
    parameter int V_FRONT        = 1,
    parameter int V_SYNC         = 4,
    parameter int V_BACK         = 23,
    parameter int HSYNC_POL      = 1,
    parameter int VSYNC_POL      = 1,
    parameter int COLOR_W        = 4,
    parameter int RD_LATCH_TICKS = 5,
    parameter int RD_GAP_TICKS   = 2,
    parameter int CHECK_SHIFT    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         fifo_data,
    input  logic               fifo_nef,
    output logic               fifo_rd_n,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int TICK_W   = $clog2(CLK_DIV + 1);
    localparam int RD_CNT_W = $clog2(RD_LATCH_TICKS + RD_GAP_TICKS + 1);
    localparam int VAL_W    = (COLOR_W > 4) ? COLOR_W : 4;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_GAP  = 2'd2
    } rd_state_t;

    // Fit the 4-bit command value to COLOR_W bits, LSB-aligned.
    // Wider channels are zero-extended; narrower ones keep the low bits.
    function automatic logic [COLOR_W-1:0] fit_val(input logic [3:0] v);
        logic [VAL_W-1:0] ext;
        ext = VAL_W'(v);
        return ext[COLOR_W-1:0];
    endfunction

    logic [TICK_W-1:0]             tick_r;
    logic [CNT_W-1:0]              h_next_s;
    logic [CNT_W-1:0]              v_next_s;
    logic                          wrap_s;
    logic                          hs_act_s;
    logic                          vs_act_s;

    logic                          nef_s;
    rd_state_t                     rd_state_r;
    logic [RD_CNT_W-1:0]           rd_cnt_r;
    logic [7:0]                    cmd_r;
    logic                          cmd_valid_r;

    // Palette index 0 = blue, 1 = green, 2 = red.
    // The cfg_* registers are the ones that command decode writes.
    logic [2:0][COLOR_W-1:0]       cfg_a_r;
    logic [2:0][COLOR_W-1:0]       cfg_b_r;
    logic [1:0]                    cfg_mode_r;
    logic [2:0][COLOR_W-1:0]       eff_a_s;
    logic [2:0][COLOR_W-1:0]       eff_b_s;
    logic [1:0]                    eff_mode_s;
    logic                          use_b_s;
    logic                          blank_s;
    logic [2:0][COLOR_W-1:0]       pix_s;

    // Next counter values, advanced only on the pixel tick.
    always_comb begin
        h_next_s = hcount;
        v_next_s = vcount;
        if (tick_r == TICK_W'(0)) begin
            if (hcount == CNT_W'(H_TOTAL - 1)) begin
                h_next_s = CNT_W'(0);
                if (vcount == CNT_W'(V_TOTAL - 1)) begin
                    v_next_s = CNT_W'(0);
                end else begin
                    v_next_s = vcount + CNT_W'(1);
                end
            end else begin
                h_next_s = hcount + CNT_W'(1);
            end
        end else begin
            h_next_s = hcount;
            v_next_s = vcount;
        end
        wrap_s   = (tick_r == TICK_W'(0)) && (h_next_s == CNT_W'(0)) && (v_next_s == CNT_W'(0));
        hs_act_s = (h_next_s >= CNT_W'(HS_START)) && (h_next_s <= CNT_W'(HS_END));
        vs_act_s = (v_next_s >= CNT_W'(VS_START)) && (v_next_s <= CNT_W'(VS_END));
    end

`ifdef VGA_CMD_FRAME_SYNC_EN
    logic [2:0][COLOR_W-1:0] act_a_r;
    logic [2:0][COLOR_W-1:0] act_b_r;
    logic [1:0]              act_mode_r;

    // Commit the shadow set on the wrap to (0,0).
    // A write decoded in this same cycle lands in cfg_* only, so it waits
    // for the following frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_a_r    <= '0;
            act_b_r    <= '0;
            act_mode_r <= 2'd0;
        end else if (wrap_s) begin
            act_a_r    <= cfg_a_r;
            act_b_r    <= cfg_b_r;
            act_mode_r <= cfg_mode_r;
        end
    end

    // Pixel (0,0) is computed on the commit edge, so it already uses the
    // new set.
    always_comb begin
        if (wrap_s) begin
            eff_a_s    = cfg_a_r;
            eff_b_s    = cfg_b_r;
            eff_mode_s = cfg_mode_r;
        end else begin
            eff_a_s    = act_a_r;
            eff_b_s    = act_b_r;
            eff_mode_s = act_mode_r;
        end
    end
`else
    // Commands act on the active registers directly.
    always_comb begin
        eff_a_s    = cfg_a_r;
        eff_b_s    = cfg_b_r;
        eff_mode_s = cfg_mode_r;
    end
`endif

    // Colour of the pixel about to be presented.
    always_comb begin
        use_b_s = 1'b0;
        blank_s = 1'b0;
        case (eff_mode_s)
            2'd0:    use_b_s = 1'b0;
            2'd1:    use_b_s = (h_next_s >= CNT_W'(H_VISIBLE / 2));
            2'd2:    use_b_s = h_next_s[CHECK_SHIFT] ^ v_next_s[CHECK_SHIFT];
            2'd3:    blank_s = 1'b1;
            default: blank_s = 1'b1;
        endcase
        if (blank_s || (h_next_s >= CNT_W'(H_VISIBLE)) || (v_next_s >= CNT_W'(V_VISIBLE))) begin
            pix_s = '0;
        end else if (use_b_s) begin
            pix_s = eff_b_s;
        end else begin
            pix_s = eff_a_s;
        end
    end

    // Pixel-rate timing and registered video outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r      <= TICK_W'(0);
            hcount      <= CNT_W'(0);
            vcount      <= CNT_W'(0);
            hsync       <= ~1'(HSYNC_POL);
            vsync       <= ~1'(VSYNC_POL);
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            tick_r      <= (tick_r == TICK_W'(CLK_DIV - 1)) ? TICK_W'(0) : tick_r + TICK_W'(1);
            frame_start <= wrap_s;
            if (tick_r == TICK_W'(0)) begin
                hcount <= h_next_s;
                vcount <= v_next_s;
                hsync  <= hs_act_s ? 1'(HSYNC_POL) : ~1'(HSYNC_POL);
                vsync  <= vs_act_s ? 1'(VSYNC_POL) : ~1'(VSYNC_POL);
                red    <= pix_s[2];
                green  <= pix_s[1];
                blue   <= pix_s[0];
            end
        end
    end

    // FIFO read FSM.
    // The GAP state lasts RD_GAP_TICKS-1 clks; the IDLE cycle that follows
    // supplies the last high clk of the strobe gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            nef_s       <= 1'b0;
            rd_state_r  <= RD_IDLE;
            rd_cnt_r    <= RD_CNT_W'(0);
            fifo_rd_n   <= 1'b1;
            cmd_r       <= 8'h00;
            cmd_valid_r <= 1'b0;
        end else begin
            nef_s       <= fifo_nef;
            cmd_valid_r <= 1'b0;
            case (rd_state_r)
                RD_IDLE: begin
                    if (nef_s) begin
                        fifo_rd_n  <= 1'b0;
                        rd_cnt_r   <= RD_CNT_W'(0);
                        rd_state_r <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt_r == RD_CNT_W'(RD_LATCH_TICKS - 1)) begin
                        cmd_r       <= fifo_data;
                        cmd_valid_r <= 1'b1;
                        fifo_rd_n   <= 1'b1;
                        rd_cnt_r    <= RD_CNT_W'(0);
                        rd_state_r  <= RD_GAP;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + RD_CNT_W'(1);
                    end
                end
                RD_GAP: begin
                    if (rd_cnt_r >= RD_CNT_W'(RD_GAP_TICKS - 2)) begin
                        rd_state_r <= RD_IDLE;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + RD_CNT_W'(1);
                    end
                end
                default: begin
                    fifo_rd_n  <= 1'b1;
                    rd_state_r <= RD_IDLE;
                end
            endcase
        end
    end

    // Command decode: [7:6] opcode, [5:4] channel index, [3:0] value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_a_r    <= '0;
            cfg_b_r    <= '0;
            cfg_mode_r <= 2'd0;
        end else if (cmd_valid_r) begin
            case (cmd_r[7:6])
                2'b00: begin
                    case (cmd_r[5:4])
                        2'd0:    cfg_a_r[0] <= fit_val(cmd_r[3:0]);
                        2'd1:    cfg_a_r[1] <= fit_val(cmd_r[3:0]);
                        2'd2:    cfg_a_r[2] <= fit_val(cmd_r[3:0]);
                        default: cfg_a_r    <= cfg_a_r;
                    endcase
                end
                2'b01: begin
                    case (cmd_r[5:4])
                        2'd0:    cfg_b_r[0] <= fit_val(cmd_r[3:0]);
                        2'd1:    cfg_b_r[1] <= fit_val(cmd_r[3:0]);
                        2'd2:    cfg_b_r[2] <= fit_val(cmd_r[3:0]);
                        default: cfg_b_r    <= cfg_b_r;
                    endcase
                end
                2'b10:   cfg_mode_r <= cmd_r[1:0];
                default: cfg_mode_r <= cfg_mode_r;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_cmd_display.sv
// ---------------------------------------------------------------------------
// tb_vga_cmd_display
//
// Directed testbench for vga_cmd_display. The timing is shrunk so whole
// frames fit in a short run:
//   horizontal: 40 + 4 + 6 + 6  = 56 pixels
//   vertical:   12 + 1 + 2 + 3  = 18 lines
// vsync polarity is 0, and the checker squares are 4 pixels wide.
// ---------------------------------------------------------------------------
module tb_vga_cmd_display;

    localparam int H_TOT = 56;
    localparam int V_TOT = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_data;
    logic        fifo_nef;
    logic        fifo_rd_n;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        frame_start;
    logic [11:0] rgb;

    int n_cmp   = 0;
    int n_fail  = 0;
    int clk_cnt = 0;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;

    vga_cmd_display #(
        .CLK_DIV(3), .CNT_W(12),
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1), .VSYNC_POL(0), .COLOR_W(4),
        .RD_LATCH_TICKS(5), .RD_GAP_TICKS(2), .CHECK_SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_nef(fifo_nef),
        .fifo_rd_n(fifo_rd_n), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .hcount(hcount), .vcount(vcount), .frame_start(frame_start)
    );

    // Wait (bounded) until the given pixel is presented.
    task automatic wait_pixel(input int h, input int v);
        bit found;
        found = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (hcount == h && vcount == v) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_pixel: (%0d,%0d) not reached in 4000 clks", h, v);
        end
    endtask

    // Perform one FIFO read of byte b and check the strobe width.
    task automatic send_cmd(input logic [7:0] b);
        bit got;
        int low;
        got       = 1'b0;
        fifo_data = b;
        fifo_nef  = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (fifo_rd_n === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_cmd_start: no read strobe for byte %h", b);
        end else begin
            low = 0;
            while (fifo_rd_n === 1'b0 && low < 50) begin
                low++;
                @(negedge clk);
            end
            n_cmp++;
            if (low !== 5) begin
                n_fail++;
                $display("FAIL rd_low_width: got %0d clks, expected 5", low);
            end
        end
        fifo_nef = 1'b0;
    endtask

    // Let a decoded command become visible.
    task automatic settle();
        repeat (4) @(negedge clk);
`ifdef VGA_CMD_FRAME_SYNC_EN
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
        end
`endif
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        fifo_nef  = 1'b0;
        fifo_data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (hcount !== 12'd0)      begin n_fail++; $display("FAIL reset_hcount: got %0d expected 0", hcount); end
        if (vcount !== 12'd0)      begin n_fail++; $display("FAIL reset_vcount: got %0d expected 0", vcount); end
        if (hsync !== 1'b0)        begin n_fail++; $display("FAIL reset_hsync: got %b expected 0", hsync); end
        if (vsync !== 1'b1)        begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
        if (rgb !== 12'h000)       begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
        if (fifo_rd_n !== 1'b1)    begin n_fail++; $display("FAIL reset_rd_n: got %b expected 1", fifo_rd_n); end
        if (frame_start !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        @(negedge clk);
        if (hcount !== 12'd0)      begin n_fail++; $display("FAIL reset_hold: hcount %0d expected 0", hcount); end
        rst = 1'b0;
    endtask

    task automatic test_timing();
        int prev_h, prev_v, last_hchg, last_hwrap, last_fs;
        int hs_bad, vs_bad, hstep_bad, hseq_bad, vseq_bad, hper_bad, fs_bad, vper_bad;
        int fs_cnt, hwraps, lines;
        bit exp_hs, exp_vs, just_wrap;
        prev_h = hcount; prev_v = vcount;
        last_hchg = -1; last_hwrap = -1; last_fs = -1;
        hs_bad = 0; vs_bad = 0; hstep_bad = 0; hseq_bad = 0; vseq_bad = 0;
        hper_bad = 0; fs_bad = 0; vper_bad = 0; fs_cnt = 0; hwraps = 0; lines = 0;
        for (int cyc = 0; cyc < 6300; cyc++) begin
            @(negedge clk);
            exp_hs = (hcount >= 44 && hcount <= 49);
            exp_vs = !(vcount >= 13 && vcount <= 14);
            if (hsync !== exp_hs) hs_bad++;
            if (vsync !== exp_vs) vs_bad++;
            just_wrap = 1'b0;
            if (hcount != prev_h) begin
                if (last_hchg >= 0 && (cyc - last_hchg) != 3) hstep_bad++;
                last_hchg = cyc;
                if (hcount != ((prev_h == H_TOT - 1) ? 0 : prev_h + 1)) hseq_bad++;
                if (prev_h == H_TOT - 1) begin
                    if (vcount != ((prev_v == V_TOT - 1) ? 0 : prev_v + 1)) vseq_bad++;
                end else if (vcount != prev_v) begin
                    vseq_bad++;
                end
                if (hcount == 0) begin
                    if (last_hwrap >= 0 && (cyc - last_hwrap) != 168) hper_bad++;
                    last_hwrap = cyc;
                    hwraps++;
                    lines++;
                    just_wrap = (vcount == 0);
                end
            end else if (vcount != prev_v) begin
                vseq_bad++;
            end
            if (frame_start !== just_wrap) fs_bad++;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0 && (cyc - last_fs) != 3024) fs_bad++;
                if (last_fs >= 0 && lines != V_TOT) vper_bad++;
                last_fs = cyc;
                lines = 0;
                fs_cnt++;
            end
            prev_h = hcount;
            prev_v = vcount;
        end
        n_cmp += 10;
        if (hs_bad !== 0)    begin n_fail++; $display("FAIL hsync_window: %0d bad clks, expected 0", hs_bad); end
        if (vs_bad !== 0)    begin n_fail++; $display("FAIL vsync_window: %0d bad clks, expected 0", vs_bad); end
        if (hstep_bad !== 0) begin n_fail++; $display("FAIL pixel_period: %0d bad steps, expected 0", hstep_bad); end
        if (hseq_bad !== 0)  begin n_fail++; $display("FAIL hcount_seq: %0d bad steps, expected 0", hseq_bad); end
        if (vseq_bad !== 0)  begin n_fail++; $display("FAIL vcount_seq: %0d bad steps, expected 0", vseq_bad); end
        if (hper_bad !== 0)  begin n_fail++; $display("FAIL line_period: %0d lines not 168 clks", hper_bad); end
        if (hwraps < 30)     begin n_fail++; $display("FAIL line_count: got %0d wraps, expected >= 30", hwraps); end
        if (fs_cnt !== 2)    begin n_fail++; $display("FAIL frame_start_count: got %0d expected 2", fs_cnt); end
        if (fs_bad !== 0)    begin n_fail++; $display("FAIL frame_start_pulse: %0d bad clks, expected 0", fs_bad); end
        if (vper_bad !== 0)  begin n_fail++; $display("FAIL frame_lines: %0d frames not 18 lines", vper_bad); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int fall_at [3];
        int low;
        bit got;
        bytes[0] = 8'h0F; bytes[1] = 8'h1A; bytes[2] = 8'h25;
        fifo_data = bytes[0];
        fifo_nef  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (fifo_rd_n === 1'b0) begin
                    got = 1'b1;
                    break;
                end
            end
            n_cmp++;
            if (!got) begin
                n_fail++;
                $display("FAIL b2b_start: read %0d never started", k);
                fifo_nef = 1'b0;
                return;
            end
            fall_at[k] = clk_cnt;
            low = 0;
            while (fifo_rd_n === 1'b0 && low < 50) begin
                low++;
                @(negedge clk);
            end
            if (k < 2) fifo_data = bytes[k+1];
            else       fifo_nef  = 1'b0;
            n_cmp++;
            if (low !== 5) begin n_fail++; $display("FAIL b2b_low_width: read %0d got %0d expected 5", k, low); end
            if (k > 0) begin
                n_cmp++;
                if ((fall_at[k] - fall_at[k-1]) < 7) begin
                    n_fail++;
                    $display("FAIL b2b_period: got %0d clks expected >= 7", fall_at[k] - fall_at[k-1]);
                end
            end
        end
    endtask

    task automatic test_palette();
        settle();
        wait_pixel(5, 3);
        n_cmp++;
        if (rgb !== 12'h5AF) begin n_fail++; $display("FAIL palette_a_5_3: got %h expected 5AF", rgb); end
        wait_pixel(30, 10);
        n_cmp++;
        if (rgb !== 12'h5AF) begin n_fail++; $display("FAIL palette_a_30_10: got %h expected 5AF", rgb); end
        wait_pixel(45, 3);
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL hblank_rgb: got %h expected 000", rgb); end
        wait_pixel(5, 14);
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL vblank_rgb: got %h expected 000", rgb); end
    endtask

    task automatic test_split();
        send_cmd(8'h4C);
        send_cmd(8'h81);
        settle();
        wait_pixel(19, 2);
        n_cmp++;
        if (rgb !== 12'h5AF) begin n_fail++; $display("FAIL split_px19: got %h expected 5AF", rgb); end
        wait_pixel(20, 2);
        n_cmp++;
        if (rgb !== 12'h00C) begin n_fail++; $display("FAIL split_px20: got %h expected 00C", rgb); end
        wait_pixel(39, 2);
        n_cmp++;
        if (rgb !== 12'h00C) begin n_fail++; $display("FAIL split_px39: got %h expected 00C", rgb); end
        wait_pixel(45, 2);
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL split_blank: got %h expected 000", rgb); end
    endtask

    task automatic test_checker();
        send_cmd(8'h82);
        settle();
        wait_pixel(1, 1);
        n_cmp++;
        if (rgb !== 12'h5AF) begin n_fail++; $display("FAIL checker_1_1: got %h expected 5AF", rgb); end
        wait_pixel(4, 1);
        n_cmp++;
        if (rgb !== 12'h00C) begin n_fail++; $display("FAIL checker_4_1: got %h expected 00C", rgb); end
        wait_pixel(9, 4);
        n_cmp++;
        if (rgb !== 12'h00C) begin n_fail++; $display("FAIL checker_9_4: got %h expected 00C", rgb); end
        wait_pixel(1, 5);
        n_cmp++;
        if (rgb !== 12'h00C) begin n_fail++; $display("FAIL checker_1_5: got %h expected 00C", rgb); end
        wait_pixel(4, 5);
        n_cmp++;
        if (rgb !== 12'h5AF) begin n_fail++; $display("FAIL checker_4_5: got %h expected 5AF", rgb); end
    endtask

    task automatic test_cmd_latency();
        wait_pixel(2, 2);
        send_cmd(8'h83);
        @(negedge clk);
        n_cmp++;
        if (rgb === 12'h000) begin n_fail++; $display("FAIL latency_before: got %h expected nonzero", rgb); end
        repeat (3) @(negedge clk);
`ifdef VGA_CMD_FRAME_SYNC_EN
        n_cmp++;
        if (rgb === 12'h000) begin n_fail++; $display("FAIL fsync_hold: got %h expected nonzero", rgb); end
        for (int t = 0; t < 4000; t++) begin
            if (frame_start === 1'b1) break;
            @(negedge clk);
        end
        n_cmp++;
        if (rgb !== 12'h000 || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fsync_commit: got rgb %h frame_start %b expected 000 1", rgb, frame_start);
        end
`else
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL latency_after: got %h expected 000", rgb); end
`endif
    endtask

    task automatic test_reset_mid_read();
        bit got;
        got       = 1'b0;
        fifo_data = 8'h2F;
        fifo_nef  = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (fifo_rd_n === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL midreset_start: read strobe never fell"); end
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        fifo_nef = 1'b0;
        @(negedge clk);
        n_cmp += 5;
        if (fifo_rd_n !== 1'b1)   begin n_fail++; $display("FAIL midreset_rd_n: got %b expected 1", fifo_rd_n); end
        if (hcount !== 12'd0)     begin n_fail++; $display("FAIL midreset_hcount: got %0d expected 0", hcount); end
        if (rgb !== 12'h000)      begin n_fail++; $display("FAIL midreset_rgb: got %h expected 000", rgb); end
        if (vsync !== 1'b1)       begin n_fail++; $display("FAIL midreset_vsync: got %b expected 1", vsync); end
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL midreset_fs: got %b expected 0", frame_start); end
        @(negedge clk);
        rst = 1'b0;
        wait_pixel(3, 1);
        n_cmp++;
        if (rgb !== 12'h000) begin n_fail++; $display("FAIL midreset_discard: got %h expected 000", rgb); end
        send_cmd(8'h2F);
        settle();
        wait_pixel(3, 1);
        n_cmp++;
        if (rgb !== 12'hF00) begin n_fail++; $display("FAIL midreset_recover: got %h expected F00", rgb); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_back_to_back();
        test_palette();
        test_split();
        test_checker();
        test_cmd_latency();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
